mem_loader: RTL
===============

Name: mem_loader

Overview:
Upstream write-side stage for the 256x16 single-port memory (ports addr[7:0], Din[15:0], clk, en; en=1 writes on the clock edge).
- Accepts a byte stream over a valid/ready handshake.
- Packs byte pairs little-endian into 16-bit words.
- Writes the words into consecutive memory addresses from START_ADDR.
- Used to preload program/data images before the core reads the memory.

Parameters:
ADDR_W, 8, memory address width
DEPTH, 256, number of words; the load ends after the word at DEPTH-1
START_ADDR, 0, first address written after start

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load; ignored unless state is IDLE or DONE
stop  input  1  early terminate request; a pending low byte is flushed
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept a byte this cycle
mem_addr  output  ADDR_W  to memory addr
mem_din  output  16  to memory Din
mem_en  output  1  to memory en; write strobe
busy  output  1  high in LOW/HIGH/WRITE
done  output  1  high in DONE; held until next start
word_count  output  ADDR_W+1  words written in current load

Behaviour:
- Reset (async, rst_n=0): state=IDLE. mem_addr=0, mem_din=0, mem_en=0, byte_ready=0, busy=0, done=0, word_count=0, internal lo/hi/stop_pending=0. Memory contents are not touched.
- States: IDLE, LOW (await low byte), HIGH (await high byte), WRITE (one-cycle strobe), DONE.
- IDLE/DONE + start: next state LOW; mem_addr<=START_ADDR; word_count<=0; stop_pending<=0. done falls the cycle after start.
- byte_ready = (state==LOW or HIGH) and !stop. A byte transfers on a rising edge with byte_valid && byte_ready.
- LOW: transfer -> lo<=byte_in, go HIGH. stop=1 -> go DONE; nothing is written.
- HIGH: transfer -> mem_din<={byte_in, lo}, go WRITE. stop=1 -> mem_din<={8'h00, lo}, stop_pending<=1, go WRITE.
- WRITE: mem_en=1 for exactly one cycle, with mem_addr/mem_din stable and registered. A stop arriving here sets stop_pending.
  - On exit: word_count+1; mem_addr+1.
  - Next state DONE if stop_pending or mem_addr==DEPTH-1, else LOW.
- Address wrap: mem_addr never wraps within a load. The final write is at DEPTH-1, then DONE.
- Throughput: minimum 3 cycles per word (LOW, HIGH, WRITE); byte_valid stalls extend LOW/HIGH indefinitely.
- byte_valid in IDLE/WRITE/DONE: ignored (ready=0); no data lost if the source honours ready.
- start in LOW/HIGH/WRITE: ignored.
- mem_en=0 in all states except WRITE. Outputs are decoded from registered state; there is no combinational path from byte_in to mem_*.
- Reset mid-load: the load aborts immediately. Words already written remain; a partial word is discarded.

Decomposition:
- Shared package mem_loader_pkg: state encoding constants (IDLE=0, LOW=1, HIGH=2, WRITE=3, DONE=4, 3-bit); default ADDR_W/DEPTH.
- Single module; no sub-module needed. Byte packing is two registers and is not split out.
- Bench instantiates mem_loader driving the existing 256x16 memory to check end-to-end.

Test Plan:
1. Reset then start; stream bytes 0x34,0x12,0x78,0x56 back-to-back -> mem_en pulses at addr 0 (din 0x1234) and addr 1 (din 0x5678), each 3 cycles apart; word_count=2, busy=1.
2. Full load: 512 bytes with byte i = i[7:0] -> word n = {(2n+1)&FF, 2n&FF} at addr n; after addr 255, done=1, busy=0, word_count=256, byte_ready=0. Memory read-back matches.
3. Stall: byte_valid toggled every other cycle, plus stop asserted in HIGH after low byte 0xAB -> write of 0x00AB at current addr; next state DONE; no further mem_en.
4. stop asserted in LOW with byte_valid=1 -> byte_ready=0, byte not consumed, DONE, no write; stop during WRITE -> current write completes, then DONE.
5. rst_n pulled low mid-HIGH -> all outputs return to reset values asynchronously, no mem_en. A subsequent start restarts at addr 0 with word_count=0.
6. start pulsed while busy -> ignored, addressing continues. start in DONE -> new load from START_ADDR; done drops the next cycle.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared state encoding and default geometry for the memory preload stage.
package mem_loader_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DEPTH  = 256;
    localparam int DATA_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write bus of the loader; master is the loader side.
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_en;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_addr, mem_din, mem_en
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_din, mem_en
    );

endinterface

// File: rtl/mem_loader.sv
// Packs a little-endian byte stream into 16-bit words and writes them to
// consecutive memory addresses starting at START_ADDR.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    mem_loader_if.master      bus,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [7:0]        lo_q, lo_d;
    logic              stop_pending_q, stop_pending_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ready;
    logic              xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            din_q          <= '0;
            lo_q           <= '0;
            stop_pending_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            din_q          <= din_d;
            lo_q           <= lo_d;
            stop_pending_q <= stop_pending_d;
            count_q        <= count_d;
        end
    end

    // stop has priority over a byte transfer; ready drops while stop is high
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        din_d          = din_q;
        lo_d           = lo_q;
        stop_pending_d = stop_pending_q;
        count_d        = count_q;
        ready          = ((state_q == ST_LOW) || (state_q == ST_HIGH)) && !stop_i;
        xfer           = bus.byte_valid && ready;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d        = ST_LOW;
                    addr_d         = FIRST_ADDR;
                    count_d        = '0;
                    stop_pending_d = 1'b0;
                end
            end
            ST_LOW: begin
                if (stop_i) begin
                    state_d = ST_DONE;
                end else if (xfer) begin
                    lo_d    = bus.byte_in;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (stop_i) begin
                    din_d          = {8'h00, lo_q};
                    stop_pending_d = 1'b1;
                    state_d        = ST_WRITE;
                end else if (xfer) begin
                    din_d   = {bus.byte_in, lo_q};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_q + 1'b1;
                addr_d  = addr_q + 1'b1;
                if (stop_i) begin
                    stop_pending_d = 1'b1;
                end
                if (stop_i || stop_pending_q || (addr_q == LAST_ADDR)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.byte_ready = ready;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = din_q;
    assign bus.mem_en     = (state_q == ST_WRITE);
    assign busy_o         = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_WRITE);
    assign done_o         = (state_q == ST_DONE);
    assign word_count_o   = count_q;

endmodule
